// File: rtl/phys_reg_free_list.sv
// Physical register free list for rename: one alloc and one release per cycle,
// with flush recovery that rewinds speculative allocations to the committed head.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PREG_W-1:0] alloc_prd,
  output logic [PREG_W-1:0] free_count,
  input  logic              commit_valid,
  input  logic              commit_has_rd,
  input  logic [PREG_W-1:0] commit_old_prd,
  input  logic              flush,
  output logic              overflow_err
);

  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam logic [PREG_W-1:0] LAST = PREG_W'(DEPTH - 1);
  localparam logic [PREG_W-1:0] FULL = PREG_W'(DEPTH);

  logic [PREG_W-1:0] entry_q [DEPTH];
  logic [PREG_W-1:0] spec_head_q;
  logic [PREG_W-1:0] commit_head_q;
  logic [PREG_W-1:0] tail_q;
  logic [PREG_W-1:0] count_q;
  logic              overflow_q;

  logic [PREG_W-1:0] spec_head_d;
  logic [PREG_W-1:0] count_d;
  logic [PREG_W-1:0] commit_head_inc;
  logic              full;
  logic              pop;
  logic              rel_req;
  logic              rel;

  function automatic logic [PREG_W-1:0] wrap_inc(
    input logic [PREG_W-1:0] p
  );
    return (p == LAST) ? '0 : p + PREG_W'(1);
  endfunction

  assign full         = (count_q == FULL);
  assign alloc_valid  = (count_q != '0) && !flush;
  assign alloc_prd    = entry_q[spec_head_q];
  assign free_count   = count_q;
  assign overflow_err = overflow_q;

  assign pop     = alloc_req && alloc_valid;
  assign rel_req = commit_valid && commit_has_rd;
  assign rel     = rel_req && !full;

  assign commit_head_inc = wrap_inc(commit_head_q);

  always_comb begin
    spec_head_d = spec_head_q;
    count_d     = count_q;
    unique case (1'b1)
      flush: begin
        spec_head_d = rel ? commit_head_inc : commit_head_q;
        count_d     = FULL;
      end
      pop && !rel: begin
        spec_head_d = wrap_inc(spec_head_q);
        count_d     = count_q - PREG_W'(1);
      end
      pop && rel: begin
        spec_head_d = wrap_inc(spec_head_q);
      end
      rel && !pop: begin
        count_d = count_q + PREG_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      count_q       <= FULL;
      overflow_q    <= 1'b0;
    end else begin
      spec_head_q <= spec_head_d;
      count_q     <= count_d;
      if (rel) begin
        tail_q        <= wrap_inc(tail_q);
        commit_head_q <= commit_head_inc;
      end
      if (rel_req && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Array reset restores the initial P32..P127 ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= PREG_W'(NUM_AREGS + i);
      end
    end else if (rel) begin
      entry_q[tail_q] <= commit_old_prd;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a queue-based free-list model
// predicts allocations; each test task compares inline.
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_req = 1'b0;
  logic       alloc_valid;
  logic [6:0] alloc_prd;
  logic [6:0] free_count;
  logic       commit_valid = 1'b0;
  logic       commit_has_rd = 1'b0;
  logic [6:0] commit_old_prd = '0;
  logic       flush = 1'b0;
  logic       overflow_err;

  int total = 0;
  int bad   = 0;

  logic [6:0] mfree[$];
  logic [6:0] inflight[$];
  bit         movf;
  logic [6:0] exp_q[$];
  logic [6:0] got_q[$];
  logic       obs_valid;
  logic       exp_valid;

  phys_reg_free_list dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (alloc_req),
    .alloc_valid    (alloc_valid),
    .alloc_prd      (alloc_prd),
    .free_count     (free_count),
    .commit_valid   (commit_valid),
    .commit_has_rd  (commit_has_rd),
    .commit_old_prd (commit_old_prd),
    .flush          (flush),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mfree.delete();
    inflight.delete();
    exp_q.delete();
    got_q.delete();
    for (int i = 32; i < 128; i++) mfree.push_back(7'(i));
    movf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // One clock of stimulus; model predicts, scoreboard records pops.
  task automatic drive(input bit req, input bit cv, input bit hd,
                       input logic [6:0] old, input bit fl);
    bit mv;
    bit p;
    bit r;
    @(negedge clk);
    alloc_req      = req;
    commit_valid   = cv;
    commit_has_rd  = hd;
    commit_old_prd = old;
    flush          = fl;
    #1;
    mv        = (mfree.size() != 0) && !fl;
    obs_valid = alloc_valid;
    exp_valid = mv;
    p         = req && mv;
    if (p) begin
      exp_q.push_back(mfree[0]);
      got_q.push_back(alloc_prd);
    end
    @(posedge clk);
    r = cv && hd && (mfree.size() != 96);
    if (cv && hd && mfree.size() == 96) movf = 1'b1;
    if (p) inflight.push_back(mfree.pop_front());
    if (r) begin
      mfree.push_back(old);
      if (inflight.size() != 0) void'(inflight.pop_front());
    end
    if (fl) begin
      mfree = {inflight, mfree};
      inflight.delete();
    end
    #1;
    alloc_req     = 1'b0;
    commit_valid  = 1'b0;
    commit_has_rd = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (alloc_valid !== 1'b1) begin
      bad++; $display("FAIL reset_valid got=%0b want=1", alloc_valid);
    end
    total++;
    if (alloc_prd !== 7'd32) begin
      bad++; $display("FAIL reset_prd got=%0d want=32", alloc_prd);
    end
    total++;
    if (free_count !== 7'd96) begin
      bad++; $display("FAIL reset_count got=%0d want=96", free_count);
    end
    total++;
    if (overflow_err !== 1'b0) begin
      bad++; $display("FAIL reset_ovf got=%0b want=0", overflow_err);
    end
  endtask

  task automatic test_alloc3();
    logic [6:0] e;
    logic [6:0] g;
    do_reset();
    repeat (3) drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e || g !== 7'(32 + i)) begin
        bad++; $display("FAIL alloc3_prd[%0d] got=%0d want=%0d", i, g, 32 + i);
      end
    end
    total++;
    if (free_count !== 7'd93) begin
      bad++; $display("FAIL alloc3_count got=%0d want=93", free_count);
    end
  endtask

  task automatic test_exhaust();
    logic [6:0] e;
    logic [6:0] g;
    int         errs;
    do_reset();
    repeat (96) drive(1, 0, 0, 0, 0);
    errs = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== e) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL exhaust_seq got=%0d_errors want=0", errs);
    end
    total++;
    if (alloc_valid !== 1'b0 || free_count !== 7'd0) begin
      bad++; $display("FAIL exhaust_empty got=%0b/%0d want=0/0", alloc_valid, free_count);
    end
    repeat (3) begin
      drive(1, 0, 0, 0, 0);
      total++;
      if (obs_valid !== 1'b0 || free_count !== 7'd0) begin
        bad++; $display("FAIL exhaust_hold got=%0b/%0d want=0/0", obs_valid, free_count);
      end
    end
    drive(0, 1, 1, 7'd1, 0);
    total++;
    if (alloc_valid !== 1'b1 || alloc_prd !== 7'd1) begin
      bad++; $display("FAIL exhaust_refill got=%0b/%0d want=1/1", alloc_valid, alloc_prd);
    end
  endtask

  task automatic test_zero_bypass();
    do_reset();
    repeat (96) drive(1, 0, 0, 0, 0);
    exp_q.delete();
    got_q.delete();
    drive(1, 1, 1, 7'd5, 0);
    total++;
    if (obs_valid !== 1'b0 || got_q.size() != 0) begin
      bad++; $display("FAIL bypass_nopop got=%0b want=0", obs_valid);
    end
    total++;
    if (alloc_prd !== 7'd5 || free_count !== 7'd1 || alloc_valid !== 1'b1) begin
      bad++; $display("FAIL bypass_next got=%0d/%0d want=5/1", alloc_prd, free_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    logic [6:0] g;
    do_reset();
    repeat (4) drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 7'd9, 0);
    drive(1, 1, 1, 7'd10, 0);
    drive(1, 1, 1, 7'd11, 0);
    total++;
    if (free_count !== 7'd92 || free_count !== 7'(mfree.size())) begin
      bad++; $display("FAIL b2b_count got=%0d want=92", free_count);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin
        bad++; $display("FAIL b2b_prd got=%0d want=%0d", g, e);
      end
    end
  endtask

  task automatic test_flush();
    logic [6:0] e;
    logic [6:0] g;
    logic [6:0] last2;
    logic [6:0] last1;
    int         errs;
    do_reset();
    repeat (5) drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 7'd1, 0);
    drive(0, 1, 1, 7'd2, 0);
    drive(1, 0, 0, 0, 1);
    total++;
    if (obs_valid !== 1'b0) begin
      bad++; $display("FAIL flush_valid got=%0b want=0", obs_valid);
    end
    total++;
    if (free_count !== 7'd96 || alloc_prd !== 7'd34) begin
      bad++; $display("FAIL flush_state got=%0d/%0d want=96/34", free_count, alloc_prd);
    end
    exp_q.delete();
    got_q.delete();
    repeat (96) drive(1, 0, 0, 0, 0);
    last2 = got_q[94];
    last1 = got_q[95];
    total++;
    if (last2 !== 7'd1 || last1 !== 7'd2) begin
      bad++; $display("FAIL flush_wrap got=%0d,%0d want=1,2", last2, last1);
    end
    errs = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== e) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL flush_seq got=%0d_errors want=0", errs);
    end
  endtask

  task automatic test_overflow_reset();
    do_reset();
    drive(0, 1, 1, 7'd7, 0);
    total++;
    if (overflow_err !== 1'b1 || overflow_err !== movf) begin
      bad++; $display("FAIL ovf_set got=%0b want=1", overflow_err);
    end
    total++;
    if (free_count !== 7'd96 || alloc_prd !== 7'd32) begin
      bad++; $display("FAIL ovf_nowrite got=%0d/%0d want=96/32", free_count, alloc_prd);
    end
    repeat (3) drive(1, 0, 0, 0, 0);
    total++;
    if (overflow_err !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got=%0b want=1", overflow_err);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (alloc_valid !== 1'b1 || alloc_prd !== 7'd32 ||
        free_count !== 7'd96 || overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got=%0b/%0d/%0d/%0b want=1/32/96/0",
               alloc_valid, alloc_prd, free_count, overflow_err);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 0, 0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 7'd32 || free_count !== 7'd95) begin
      bad++; $display("FAIL post_reset got=%0d want=95", free_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alloc3();
    test_exhaust();
    test_zero_bypass();
    test_back_to_back();
    test_flush();
    test_overflow_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
